// File: rtl/alu_pkg.sv
// Shared ALU encodings and arbiter state type for the shared-ALU arbiter.
package alu_pkg;

    // ALUOp codes as presented to ALU_Ctrl
    localparam logic [2:0] ALUOP_BEQ    = 3'b001;
    localparam logic [2:0] ALUOP_R_TYPE = 3'b010;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_SLTI   = 3'b101;
    localparam logic [2:0] ALUOP_LUI    = 3'b110;
    localparam logic [2:0] ALUOP_ORI    = 3'b111;

    // funct codes decoded by ALU_Ctrl when ALUOp is R_type
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to ptr_i.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    // One-hot grant; ties resolved by the round-robin pointer
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, registered
// operands to the ALU, result/zero held until the owner accepts them.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_aluop_i,
    input  logic [5:0]        req0_funct_i,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_aluop_i,
    input  logic [5:0]        req1_funct_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_result_o,
    output logic              rsp0_zero_o,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_result_o,
    output logic              rsp1_zero_o,
    output logic [2:0]        alu_op_o,
    output logic [5:0]        alu_funct_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              busy_o
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    arb_state_e        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [2:0]        op_q, op_d;
    logic [5:0]        funct_q, funct_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;

    logic [1:0] grant;
    logic       own_rsp_ready;

    rr_arbiter2 u_rr (
        .valid_i (
            {req1_valid_i, req0_valid_i}
        ),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    assign req0_ready_o  = (state_q == ST_IDLE) & grant[0];
    assign req1_ready_o  = (state_q == ST_IDLE) & grant[1];
    assign own_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;

    // Next-state: grant in IDLE, count ALU hold cycles in EXEC, wait for accept in RESP
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        op_d     = op_q;
        funct_d  = funct_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        res_d    = res_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (grant[0] | grant[1]) begin
                    owner_d = grant[1];
                    op_d    = grant[1] ? req1_aluop_i : req0_aluop_i;
                    funct_d = grant[1] ? req1_funct_i : req0_funct_i;
                    src1_d  = grant[1] ? req1_src1_i  : req0_src1_i;
                    src2_d  = grant[1] ? req1_src2_i  : req0_src2_i;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Counter tops out at ALU_LAT, which fits CW bits, so no wrap
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = alu_result_i;
                    zero_d  = alu_zero_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (own_rsp_ready) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            funct_q  <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            funct_q  <= funct_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
        end
    end

    // ALU sees the latched operation only while executing
    assign alu_op_o    = (state_q == ST_EXEC) ? op_q    : '0;
    assign alu_funct_o = (state_q == ST_EXEC) ? funct_q : '0;
    assign alu_src1_o  = (state_q == ST_EXEC) ? src1_q  : '0;
    assign alu_src2_o  = (state_q == ST_EXEC) ? src2_q  : '0;

    assign rsp0_valid_o  = (state_q == ST_RESP) & ~owner_q;
    assign rsp1_valid_o  = (state_q == ST_RESP) &  owner_q;
    assign rsp0_result_o = owner_q ? '0 : res_q;
    assign rsp1_result_o = owner_q ? res_q : '0;
    assign rsp0_zero_o   = ~owner_q & zero_q;
    assign rsp1_zero_o   =  owner_q & zero_q;

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic on an
// ALU_LAT=1 and an ALU_LAT=3 instance, checked against a transaction model.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance DUT connections, index [inst] or [inst][requester]
    logic        rst_n       [2];
    logic        req_valid   [2][2];
    logic        req_ready   [2][2];
    logic [2:0]  req_op      [2][2];
    logic [5:0]  req_funct   [2][2];
    logic [31:0] req_s1      [2][2];
    logic [31:0] req_s2      [2][2];
    logic        rsp_valid   [2][2];
    logic        rsp_ready   [2][2];
    logic [31:0] rsp_res     [2][2];
    logic        rsp_zero    [2][2];
    logic [2:0]  alu_op      [2];
    logic [5:0]  alu_funct   [2];
    logic [31:0] alu_s1      [2];
    logic [31:0] alu_s2      [2];
    logic        busy        [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural ALU + ALU_Ctrl; unknown codes give all ones
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALUOP_R_TYPE: begin
                case (f)
                    FUNCT_ADD: return a + b;
                    FUNCT_SUB: return a - b;
                    FUNCT_AND: return a & b;
                    FUNCT_OR:  return a | b;
                    FUNCT_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default:   return 32'hFFFF_FFFF;
                endcase
            end
            ALUOP_BEQ:  return a - b;
            ALUOP_ADDI: return a + b;
            ALUOP_SLTI: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALUOP_LUI:  return {b[15:0], 16'h0000};
            ALUOP_ORI:  return a | b;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [72:0] cur;
        logic [72:0] last = '0;
        int          hold = 0;
        int          stable;
        logic [31:0] res_l;
        logic        zero_l;

        // The ALU model only settles after its inputs have been steady LAT cycles;
        // before that it returns a poison value so an early sample is visible
        assign cur = {alu_op[g], alu_funct[g], alu_s1[g], alu_s2[g]};
        always @(posedge clk) begin
            if (cur != last) begin
                last <= cur;
                hold <= 0;
            end else begin
                hold <= hold + 1;
            end
        end
        always_comb begin
            stable = (cur == last) ? hold + 1 : 0;
            res_l  = (stable >= LAT - 1) ? alu_fn(alu_op[g], alu_funct[g], alu_s1[g], alu_s2[g])
                                         : 32'hBAD0_BAD0;
            zero_l = (res_l == 32'd0);
        end

        alu_share_arbiter #(.DATA_W(32), .ALU_LAT(LAT)) u_dut (
            .clk_i         (clk),
            .rst_i         (rst_n[g]),
            .req0_valid_i  (req_valid[g][0]),
            .req0_ready_o  (req_ready[g][0]),
            .req0_aluop_i  (req_op[g][0]),
            .req0_funct_i  (req_funct[g][0]),
            .req0_src1_i   (req_s1[g][0]),
            .req0_src2_i   (req_s2[g][0]),
            .req1_valid_i  (req_valid[g][1]),
            .req1_ready_o  (req_ready[g][1]),
            .req1_aluop_i  (req_op[g][1]),
            .req1_funct_i  (req_funct[g][1]),
            .req1_src1_i   (req_s1[g][1]),
            .req1_src2_i   (req_s2[g][1]),
            .rsp0_valid_o  (rsp_valid[g][0]),
            .rsp0_ready_i  (rsp_ready[g][0]),
            .rsp0_result_o (rsp_res[g][0]),
            .rsp0_zero_o   (rsp_zero[g][0]),
            .rsp1_valid_o  (rsp_valid[g][1]),
            .rsp1_ready_i  (rsp_ready[g][1]),
            .rsp1_result_o (rsp_res[g][1]),
            .rsp1_zero_o   (rsp_zero[g][1]),
            .alu_op_o      (alu_op[g]),
            .alu_funct_o   (alu_funct[g]),
            .alu_src1_o    (alu_s1[g]),
            .alu_src2_o    (alu_s2[g]),
            .alu_result_i  (res_l),
            .alu_zero_i    (zero_l),
            .busy_o        (busy[g])
        );
    end

    // Stimulus applied to whichever instance is under test
    logic        b_rst;
    logic        b_v     [2];
    logic [2:0]  b_op    [2];
    logic [5:0]  b_funct [2];
    logic [31:0] b_s1    [2];
    logic [31:0] b_s2    [2];
    logic        b_rdy   [2];

    // Transaction model: owner (-1 = free), cycles since grant, rr pointer
    int          m_own = -1;
    int          m_age = 0;
    int          m_ptr = 0;
    logic [2:0]  m_op;
    logic [5:0]  m_funct;
    logic [31:0] m_s1, m_s2, m_res;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner();
        if (b_v[0] && b_v[1]) return m_ptr;
        if (b_v[0]) return 0;
        if (b_v[1]) return 1;
        return -1;
    endfunction

    task automatic set_req(input int n, input logic [2:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
        b_v[n] = 1'b1; b_op[n] = op; b_funct[n] = f; b_s1[n] = a; b_s2[n] = b;
    endtask

    task automatic new_req(input int n);
        logic [5:0] f;
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: f = FUNCT_ADD;
            1: f = FUNCT_SUB;
            2: f = FUNCT_AND;
            3: f = FUNCT_OR;
            4: f = FUNCT_SLT;
            default: f = 6'($urandom_range(0, 63));
        endcase
        a = $urandom;
        set_req(n, 3'($urandom_range(0, 7)), f, a, ($urandom_range(0, 3) == 0) ? a : $urandom);
    endtask

    // Apply stimulus at the falling edge, then compare outputs to the model
    task automatic drive_check(input int k);
        int  w;
        bit  drv;
        @(negedge clk);
        rst_n[k] = b_rst;
        for (int n = 0; n < 2; n++) begin
            req_valid[k][n] = b_v[n];
            req_op[k][n]    = b_op[n];
            req_funct[k][n] = b_funct[n];
            req_s1[k][n]    = b_s1[n];
            req_s2[k][n]    = b_s2[n];
            rsp_ready[k][n] = b_rdy[n];
        end
        #1;
        if (chk_en) begin
            w   = winner();
            drv = (m_own >= 0) && (m_age <= lat(k));
            chk("ready0", req_ready[k][0], (m_own < 0) && (w == 0));
            chk("ready1", req_ready[k][1], (m_own < 0) && (w == 1));
            chk("busy",   busy[k], m_own >= 0);
            chk("alu_op",    alu_op[k],    drv ? m_op    : 3'd0);
            chk("alu_funct", alu_funct[k], drv ? m_funct : 6'd0);
            chk("alu_src1",  alu_s1[k],    drv ? m_s1    : 32'd0);
            chk("alu_src2",  alu_s2[k],    drv ? m_s2    : 32'd0);
            for (int n = 0; n < 2; n++) begin
                chk("rsp_valid", rsp_valid[k][n], (m_own == n) && (m_age > lat(k)));
                if ((m_own == n) && (m_age > lat(k))) begin
                    chk("rsp_result", rsp_res[k][n], m_res);
                    chk("rsp_zero",   rsp_zero[k][n], m_res == 32'd0);
                end
            end
        end
    endtask

    // Advance the model across the rising edge
    task automatic tick(input int k);
        int w;
        @(posedge clk);
        if (!b_rst) begin
            m_own = -1; m_age = 0; m_ptr = 0;
        end else if (m_own < 0) begin
            w = winner();
            if (w >= 0) begin
                m_own = w; m_age = 1;
                m_op = b_op[w]; m_funct = b_funct[w]; m_s1 = b_s1[w]; m_s2 = b_s2[w];
                m_res = alu_fn(m_op, m_funct, m_s1, m_s2);
                b_v[w] = 1'b0;
            end
        end else if (m_age > lat(k)) begin
            if (b_rdy[m_own]) begin
                m_ptr = 1 - m_own;
                m_own = -1;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic wait_rsp(input int k, input int n, input logic [31:0] res,
                            input logic z, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            drive_check(k);
            if (rsp_valid[k][n] === 1'b1) begin
                seen = 1'b1;
                chk({tag, "_result"}, rsp_res[k][n], res);
                chk({tag, "_zero"},   rsp_zero[k][n], z);
            end
            tick(k);
        end
        if (!seen) chk({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic run_random(input int k, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!b_v[n] && $urandom_range(0, 2) == 0) new_req(n);
                b_rdy[n] = 1'($urandom_range(0, 1));
            end
            b_rst = ($urandom_range(0, 39) != 0);
            drive_check(k);
            tick(k);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; busy_dummy_clear(k);
        end
        b_rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            b_v[n] = 1'b0; b_op[n] = '0; b_funct[n] = '0; b_s1[n] = '0; b_s2[n] = '0;
            b_rdy[n] = 1'b0;
        end

        // Reset held two cycles, then outputs must all be idle/zero
        drive_check(0); tick(0);
        drive_check(0); tick(0);
        chk_en = 1'b1;
        drive_check(0);
        chk("rst_res0", rsp_res[0][0], 32'd0);
        chk("rst_res1", rsp_res[0][1], 32'd0);
        chk("rst_zero0", rsp_zero[0][0], 1'b0);
        chk("rst_zero1", rsp_zero[0][1], 1'b0);
        tick(0);

        // Single ADDi on requester 0: ready@T, ALU@T+1, response@T+2
        b_rst = 1'b1; b_rdy[0] = 1'b1; b_rdy[1] = 1'b1;
        set_req(0, ALUOP_ADDI, 6'd0, 32'd5, 32'd7);
        drive_check(0); chk("t2_ready0", req_ready[0][0], 1'b1); tick(0);
        drive_check(0);
        chk("t2_alu_op", alu_op[0], ALUOP_ADDI);
        chk("t2_src1", alu_s1[0], 32'd5);
        chk("t2_src2", alu_s2[0], 32'd7);
        tick(0);
        drive_check(0);
        chk("t2_rsp_valid", rsp_valid[0][0], 1'b1);
        chk("t2_result", rsp_res[0][0], 32'd12);
        chk("t2_zero", rsp_zero[0][0], 1'b0);
        tick(0);

        // Contention after reset: requester 0 first, then 1, then 0 again
        b_rst = 1'b0; drive_check(0); tick(0); b_rst = 1'b1;
        set_req(0, ALUOP_R_TYPE, FUNCT_SUB, 32'd9, 32'd9);
        set_req(1, ALUOP_ORI, 6'd0, 32'd3, 32'd4);
        drive_check(0);
        chk("t3_ready0", req_ready[0][0], 1'b1);
        chk("t3_ready1", req_ready[0][1], 1'b0);
        tick(0);
        wait_rsp(0, 0, 32'd0, 1'b1, "t3_rsp0");
        wait_rsp(0, 1, 32'd7, 1'b0, "t3_rsp1");
        set_req(0, ALUOP_ADDI, 6'd0, 32'd1, 32'd2);
        set_req(1, ALUOP_ADDI, 6'd0, 32'd10, 32'd20);
        drive_check(0);
        chk("t3_again_ready0", req_ready[0][0], 1'b1);
        chk("t3_again_ready1", req_ready[0][1], 1'b0);
        tick(0);

        // Owner stalls its response: result held, other requester locked out
        b_rdy[0] = 1'b0;
        drive_check(0); tick(0);
        for (int i = 0; i < 5; i++) begin
            drive_check(0);
            chk("t4_hold_valid", rsp_valid[0][0], 1'b1);
            chk("t4_hold_result", rsp_res[0][0], 32'd3);
            chk("t4_ready1_low", req_ready[0][1], 1'b0);
            chk("t4_busy", busy[0], 1'b1);
            tick(0);
        end
        b_rdy[0] = 1'b1;
        drive_check(0); tick(0);
        drive_check(0); chk("t4_ready1", req_ready[0][1], 1'b1); tick(0);
        wait_rsp(0, 1, 32'd30, 1'b0, "t4_rsp1");

        // Reset while executing drops the transaction and restores req0 priority
        set_req(0, ALUOP_LUI, 6'd0, 32'd0, 32'h1234);
        drive_check(0); tick(0);
        b_rst = 1'b0; drive_check(0); tick(0); b_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_check(0);
            chk("t5_no_rsp0", rsp_valid[0][0], 1'b0);
            tick(0);
        end
        set_req(0, ALUOP_ADDI, 6'd0, 32'd2, 32'd2);
        set_req(1, ALUOP_ADDI, 6'd0, 32'd0, 32'd0);
        drive_check(0); chk("t5_ptr_ready0", req_ready[0][0], 1'b1); tick(0);
        wait_rsp(0, 0, 32'd4, 1'b0, "t5_rsp0");
        wait_rsp(0, 1, 32'd0, 1'b1, "t5_rsp1");

        run_random(0, 500);

        // Second instance with ALU_LAT=3
        chk_en = 1'b0; b_rst = 1'b0; b_v[0] = 1'b0; b_v[1] = 1'b0;
        drive_check(1); tick(1);
        chk_en = 1'b1; b_rst = 1'b1; b_rdy[0] = 1'b1; b_rdy[1] = 1'b1;
        set_req(0, ALUOP_ADDI, 6'd0, 32'd5, 32'd7);
        drive_check(1); chk("t6_ready0", req_ready[1][0], 1'b1); tick(1);
        for (int i = 0; i < 3; i++) begin
            drive_check(1);
            chk("t6_alu_op", alu_op[1], ALUOP_ADDI);
            chk("t6_src1", alu_s1[1], 32'd5);
            chk("t6_no_rsp", rsp_valid[1][0], 1'b0);
            tick(1);
        end
        drive_check(1);
        chk("t6_rsp_valid", rsp_valid[1][0], 1'b1);
        chk("t6_result", rsp_res[1][0], 32'd12);
        tick(1);

        run_random(1, 500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Idle every input of an instance so nothing floats before it is exercised
    task automatic busy_dummy_clear(input int k);
        for (int n = 0; n < 2; n++) begin
            req_valid[k][n] = 1'b0; req_op[k][n] = '0; req_funct[k][n] = '0;
            req_s1[k][n] = '0; req_s2[k][n] = '0; rsp_ready[k][n] = 1'b0;
        end
    endtask

endmodule
